// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a valid/ready input handshake and an iterative
// shift-add multiplier (one step per clock).
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   in_valid       operation request; taken when in_valid && out_ready
//   in_a, in_b     operands (in_b[SHAMT_W-1:0] doubles as shift amount)
//   in_ctrl_aluop  4-bit opcode
//   out_ready      high while idle (combinational from state)
//   out_valid      one-cycle pulse when result/flags were written
//   out_result     registered result
//   out_zero/neg   derived from the freshly written result
//   out_carry/ovf  carry (or no-borrow) and signed overflow, per opcode
module alu_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_ctrl_aluop,
  output logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf
);

  typedef enum logic [3:0] {
    OP_SUB  = 4'b0000,
    OP_NEG  = 4'b0001,
    OP_INC  = 4'b0010,
    OP_NOP  = 4'b0011,
    OP_ADD  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_OR   = 4'b0110,
    OP_PASS = 4'b0111,
    OP_SHL  = 4'b1000,
    OP_SHR  = 4'b1001,
    OP_MUL  = 4'b1010
  } aluop_e;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] SMIN     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SMAX     = ~SMIN;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;

  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               neg_q;
  logic               carry_q;
  logic               ovf_q;
  logic               valid_q;

  aluop_e             op;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     ext;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_c;
  logic               alu_v;
  logic               alu_hold;

  assign op    = aluop_e'(in_ctrl_aluop);
  assign shamt = in_b[SHAMT_W-1:0];

  // Single-cycle datapath. ext carries one extra bit: the carry for
  // add-type ops, the last bit shifted out for shifts.
  always_comb begin
    ext      = '0;
    alu_r    = result_q;
    alu_c    = carry_q;
    alu_v    = ovf_q;
    alu_hold = 1'b0;
    case (op)
      OP_SUB: begin
        ext   = {1'b0, in_b} + {1'b0, ~in_a} + (WIDTH+1)'(1);
        alu_r = ext[WIDTH-1:0];
        alu_c = ext[WIDTH];
        alu_v = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (ext[WIDTH-1] != in_b[WIDTH-1]);
      end
      OP_NEG: begin
        alu_r = ~in_a + WIDTH'(1);
        alu_c = 1'b0;
        alu_v = (in_a == SMIN);
      end
      OP_INC: begin
        ext   = {1'b0, in_a} + (WIDTH+1)'(1);
        alu_r = ext[WIDTH-1:0];
        alu_c = ext[WIDTH];
        alu_v = (in_a == SMAX);
      end
      OP_ADD: begin
        ext   = {1'b0, in_a} + {1'b0, in_b};
        alu_r = ext[WIDTH-1:0];
        alu_c = ext[WIDTH];
        alu_v = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (ext[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND: begin
        alu_r = in_a & in_b;
        alu_c = 1'b0;
        alu_v = 1'b0;
      end
      OP_OR: begin
        alu_r = in_a | in_b;
        alu_c = 1'b0;
        alu_v = 1'b0;
      end
      OP_PASS: begin
        alu_r = in_a;
        alu_c = 1'b0;
        alu_v = 1'b0;
      end
      OP_SHL: begin
        ext   = {1'b0, in_a} << shamt;
        alu_r = ext[WIDTH-1:0];
        alu_c = ext[WIDTH];
        alu_v = 1'b0;
      end
      OP_SHR: begin
        ext   = {in_a, 1'b0} >> shamt;
        alu_r = ext[WIDTH:1];
        alu_c = ext[0];
        alu_v = 1'b0;
      end
      default: alu_hold = 1'b1;  // NOP, reserved codes; MUL never uses this path
    endcase
  end

  // One shift-add step: multiplier consumed LSB first, multiplicand moves left.
  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (state_q == S_IDLE) begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            state_q  <= S_MUL;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, in_a};
            mplier_q <= in_b;
          end else begin
            valid_q <= 1'b1;
            if (!alu_hold) begin
              result_q <= alu_r;
              zero_q   <= (alu_r == '0);
              neg_q    <= alu_r[WIDTH-1];
              carry_q  <= alu_c;
              ovf_q    <= alu_v;
            end
          end
        end
      end else begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_q  <= S_IDLE;
          cnt_q    <= '0;
          valid_q  <= 1'b1;
          result_q <= acc_d[WIDTH-1:0];
          zero_q   <= (acc_d[WIDTH-1:0] == '0);
          neg_q    <= acc_d[WIDTH-1];
          carry_q  <= 1'b0;
          ovf_q    <= |acc_d[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

  assign out_ready  = (state_q == S_IDLE);
  assign out_valid  = valid_q;
  assign out_result = result_q;
  assign out_zero   = zero_q;
  assign out_neg    = neg_q;
  assign out_carry  = carry_q;
  assign out_ovf    = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: one 32-bit and one 8-bit instance.
// Drivers push expected {result, Z N C V, due edge} when they issue a request;
// per-instance monitors pop and compare whenever out_valid is seen.
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    int          due;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];

  logic        rst32_n = 1'b1;
  logic        v32     = 1'b0;
  logic [31:0] a32     = '0;
  logic [31:0] b32     = '0;
  logic [3:0]  op32    = '0;
  logic        rdy32, val32, z32, n32, c32, ov32;
  logic [31:0] res32;

  logic        rst8_n  = 1'b1;
  logic        v8      = 1'b0;
  logic [7:0]  a8      = '0;
  logic [7:0]  b8      = '0;
  logic [3:0]  op8     = '0;
  logic        rdy8, val8, z8, n8, c8, ov8;
  logic [7:0]  res8;

  alu_seq #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst32_n), .in_valid(v32), .in_a(a32), .in_b(b32),
    .in_ctrl_aluop(op32), .out_ready(rdy32), .out_valid(val32),
    .out_result(res32), .out_zero(z32), .out_neg(n32), .out_carry(c32), .out_ovf(ov32)
  );

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(v8), .in_a(a8), .in_b(b8),
    .in_ctrl_aluop(op8), .out_ready(rdy8), .out_valid(val8),
    .out_result(res8), .out_zero(z8), .out_neg(n8), .out_carry(c8), .out_ovf(ov8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Waits for ready at a falling edge, presents the request for the next
  // rising edge, and (optionally) records what that request must produce.
  task automatic issue(input bit w8, input bit push, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic [3:0] f);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    while (!(w8 ? rdy8 : rdy32) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      check(w8 ? "ready8_wait" : "ready32_wait", 64'(w8 ? rdy8 : rdy32), 1);
      return;
    end
    e.r   = r;
    e.f   = f;
    e.due = cyc + 1 + ((op == 4'b1010) ? (w8 ? 8 : 32) : 0);
    if (w8) begin
      v8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
      if (push) q8.push_back(e);
    end else begin
      v32 = 1'b1; op32 = op; a32 = a; b32 = b;
      if (push) q32.push_back(e);
    end
  endtask

  task automatic idle(input bit w8);
    @(negedge clk);
    if (w8) v8 = 1'b0;
    else    v32 = 1'b0;
  endtask

  always begin : mon32
    exp_t e;
    @(posedge clk);
    #1;
    if (val32) begin
      check("valid32_expected", 64'(q32.size() > 0), 1);
      if (q32.size() > 0) begin
        e = q32.pop_front();
        check("result32", res32, e.r);
        check("flags32", {z32, n32, c32, ov32}, e.f);
        check("latency32", cyc, e.due);
      end
    end else if (q32.size() > 0 && cyc >= q32[0].due) begin
      check("valid32_on_time", val32, 1);
      void'(q32.pop_front());
    end
  end

  always begin : mon8
    exp_t e;
    @(posedge clk);
    #1;
    if (val8) begin
      check("valid8_expected", 64'(q8.size() > 0), 1);
      if (q8.size() > 0) begin
        e = q8.pop_front();
        check("result8", res8, e.r);
        check("flags8", {z8, n8, c8, ov8}, e.f);
        check("latency8", cyc, e.due);
      end
    end else if (q8.size() > 0 && cyc >= q8[0].due) begin
      check("valid8_on_time", val8, 1);
      void'(q8.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    rst32_n = 1'b0;
    rst8_n  = 1'b0;
    #1;
    check("reset32_outputs", {res32, z32, n32, c32, ov32, val32}, '0);
    check("reset8_outputs", {res8, z8, n8, c8, ov8, val8}, '0);
    @(negedge clk);
    rst32_n = 1'b1;
    rst8_n  = 1'b1;
    #1;
    check("ready32_after_reset", rdy32, 1);
    check("ready8_after_reset", rdy8, 1);

    // 32-bit: back-to-back single-cycle ops (flags = {Z,N,C,V})
    issue(0, 1, 4'b0100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010); // ADD
    issue(0, 1, 4'b1100, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 4'b1010); // reserved = NOP
    issue(0, 1, 4'b0000, 32'h0000_0005, 32'h0000_0003, 32'hFFFF_FFFE, 4'b0100); // SUB 3-5
    issue(0, 1, 4'b0000, 32'h0000_0003, 32'h0000_0005, 32'h0000_0002, 4'b0010); // SUB 5-3
    issue(0, 1, 4'b0000, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 4'b0101); // SUB ovf

    // MUL, busy window, dropped request
    issue(0, 1, 4'b1010, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b1001);
    @(negedge clk);
    v32 = 1'b0;
    check("busy_ready32", rdy32, 0);
    check("busy_hold32", {res32, z32, n32, c32, ov32}, {32'h8000_0000, 4'b0101});
    @(negedge clk);
    v32 = 1'b1; op32 = 4'b0100; a32 = 32'h1; b32 = 32'h1;
    @(negedge clk);
    v32 = 1'b0;
    check("busy_ready32_later", rdy32, 0);
    issue(0, 1, 4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0001);
    check("accept_in_valid_cycle", val32, 1);
    issue(0, 1, 4'b1010, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 4'b0000);

    issue(0, 1, 4'b0001, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0100); // NEG
    issue(0, 1, 4'b0001, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 4'b0101); // NEG MIN
    issue(0, 1, 4'b0010, 32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000, 4'b0101); // INC MAX
    issue(0, 1, 4'b0010, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 4'b1010); // INC wrap
    issue(0, 1, 4'b0100, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101); // ADD ovf
    issue(0, 1, 4'b0101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b0100); // AND
    issue(0, 1, 4'b0110, 32'h0F0F_0000, 32'h00F0_000F, 32'h0FFF_000F, 4'b0000); // OR
    issue(0, 1, 4'b0111, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 4'b0000); // PASS
    issue(0, 1, 4'b1000, 32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 4'b0010); // SHL 1
    issue(0, 1, 4'b1001, 32'h8000_0001, 32'h0000_0000, 32'h8000_0001, 4'b0100); // SHR 0
    issue(0, 1, 4'b0011, 32'h0000_0000, 32'h0000_0000, 32'h8000_0001, 4'b0100); // NOP
    issue(0, 1, 4'b1000, 32'h0000_0003, 32'h0000_001F, 32'h8000_0000, 4'b0110); // SHL 31
    issue(0, 1, 4'b1001, 32'hC000_0000, 32'h0000_001F, 32'h0000_0001, 4'b0010); // SHR 31
    issue(0, 1, 4'b1000, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 4'b0000); // SHL, s from low bits
    issue(0, 1, 4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b0110); // ADD carry
    issue(0, 1, 4'b0011, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFE, 4'b0110); // NOP holds C
    issue(0, 1, 4'b1011, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 4'b0110); // reserved
    issue(0, 1, 4'b0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b1010); // SUB equal
    idle(0);

    // mid-cycle reset on the 32-bit instance
    repeat (3) @(negedge clk);
    #2;
    rst32_n = 1'b0;
    #1;
    check("midreset32_outputs", {res32, z32, n32, c32, ov32, val32}, '0);
    @(negedge clk);
    rst32_n = 1'b1;
    #1;
    check("midreset32_ready", rdy32, 1);

    // 8-bit instance
    issue(1, 1, 4'b1010, 32'h0F, 32'h11, 32'hFF, 4'b0100); // 15*17
    issue(1, 1, 4'b1010, 32'h10, 32'h10, 32'h00, 4'b1001); // 16*16 overflows
    issue(1, 1, 4'b0100, 32'hFF, 32'h01, 32'h00, 4'b1010); // ADD wrap
    issue(1, 0, 4'b1010, 32'h0F, 32'h11, 32'h00, 4'b0000); // aborted by reset
    @(negedge clk);
    v8 = 1'b0;
    repeat (4) @(negedge clk);
    check("mul8_busy_ready", rdy8, 0);
    #2;
    rst8_n = 1'b0;
    #1;
    check("abort8_outputs", {res8, z8, n8, c8, ov8, val8}, '0);
    check("abort8_ready", rdy8, 1);
    @(negedge clk);
    rst8_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort8_ready_after", rdy8, 1);
    issue(1, 1, 4'b0100, 32'h7F, 32'h01, 32'h80, 4'b0101); // ADD ovf after abort
    idle(1);

    for (int i = 0; i < 100 && (q32.size() > 0 || q8.size() > 0); i++) @(negedge clk);
    check("q32_drained", q32.size(), 0);
    check("q8_drained", q8.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
